// File: rtl/lzw_pkg.sv
// Shared LZW dictionary types and sizing constants.
// Keys are {prefix code, next char}; codes below CODE_BASE are literal symbols.
package lzw_pkg;

  localparam int CHAR_W    = 8;
  localparam int CODE_W    = 11;
  localparam int CODE_BASE = 256;
  localparam int DEPTH     = 2**CODE_W - CODE_BASE;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [CHAR_W-1:0] char_t;

  typedef struct packed {
    code_t prefix;
    char_t ch;
  } key_t;

  localparam int KEY_W = $bits(key_t);

endpackage

// File: rtl/cam_slot.sv
// One dictionary slot: key register, valid bit and equality compare.
// match is combinational from the registered contents; writes land on the rising edge.
module cam_slot #(
  parameter int KEY_W = lzw_pkg::KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [KEY_W-1:0] search_key,
  output logic             match
);

  logic             valid;
  logic [KEY_W-1:0] key;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      key   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      key   <= wr_key;
    end
  end

  assign match = valid && (key == search_key);

endmodule

// File: rtl/lzw_cam_dict.sv
// LZW dictionary CAM: search-or-insert with one-cycle registered response, one request per cycle.
// No output backpressure; clear takes priority over and blocks any concurrent request.
module lzw_cam_dict #(
  parameter int CHAR_W    = lzw_pkg::CHAR_W,
  parameter int CODE_W    = lzw_pkg::CODE_W,
  parameter int KEY_W     = CODE_W + CHAR_W,
  parameter int CODE_BASE = lzw_pkg::CODE_BASE,
  parameter int DEPTH     = 2**CODE_W - CODE_BASE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_insert,
  input  logic [KEY_W-1:0]           req_key,
  output logic                       rsp_valid,
  output logic                       rsp_hit,
  output logic                       rsp_inserted,
  output logic [CODE_W-1:0]          rsp_code,
  output logic                       cam_full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] wr_en;
  logic             accept;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             ins_go;
  logic [CODE_W-1:0] hit_code;
  logic [CODE_W-1:0] new_code;

  assign req_ready = ~clear;
  assign accept    = req_valid && req_ready;
  assign ins_go    = accept && !hit_any && req_insert && !cam_full;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      assign wr_en[i] = ins_go && (count == CNT_W'(i));

      cam_slot #(
        .KEY_W (KEY_W)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .wr_en      (wr_en[i]),
        .wr_key     (req_key),
        .search_key (req_key),
        .match      (match[i])
      );
    end
  endgenerate

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (match[j]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(j);
      end
    end
  end

  assign hit_code = CODE_W'(CODE_BASE) + CODE_W'(hit_idx);
  assign new_code = CODE_W'(CODE_BASE) + CODE_W'(count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      cam_full <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      cam_full <= 1'b0;
    end else if (ins_go) begin
      count    <= count + CNT_W'(1);
      cam_full <= ((count + CNT_W'(1)) == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid    <= 1'b0;
      rsp_hit      <= 1'b0;
      rsp_inserted <= 1'b0;
      rsp_code     <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_hit      <= hit_any;
        rsp_inserted <= ins_go;
        if (hit_any)
          rsp_code <= hit_code;
        else if (ins_go)
          rsp_code <= new_code;
        else
          rsp_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lzw_cam_dict.sv
// Scoreboard bench for lzw_cam_dict at DEPTH=4, CODE_BASE=256.
module tb_lzw_cam_dict;

  typedef struct packed {
    logic        hit;
    logic        ins;
    logic [10:0] code;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic        req_insert;
  logic [18:0] req_key;
  logic        rsp_valid;
  logic        rsp_hit;
  logic        rsp_inserted;
  logic [10:0] rsp_code;
  logic        cam_full;
  logic [2:0]  count;

  int errors;
  int checks;
  exp_t sb[$];
  logic [18:0] model_keys[$];

  lzw_cam_dict #(
    .CHAR_W    (8),
    .CODE_W    (11),
    .KEY_W     (19),
    .CODE_BASE (256),
    .DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_insert   (req_insert),
    .req_key      (req_key),
    .rsp_valid    (rsp_valid),
    .rsp_hit      (rsp_hit),
    .rsp_inserted (rsp_inserted),
    .rsp_code     (rsp_code),
    .cam_full     (cam_full),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic predict(input logic ins, input logic [18:0] key);
    exp_t e;
    int idx;
    idx = -1;
    e = '0;
    foreach (model_keys[k])
      if (idx < 0 && model_keys[k] == key) idx = k;
    if (idx >= 0) begin
      e.hit  = 1'b1;
      e.code = 11'(256 + idx);
    end else if (ins && model_keys.size() < 4) begin
      e.ins  = 1'b1;
      e.code = 11'(256 + model_keys.size());
      model_keys.push_back(key);
    end
    sb.push_back(e);
  endtask

  // Drives one request at a falling edge and returns at the next falling edge.
  task automatic issue(input logic ins, input logic [18:0] key);
    req_valid  = 1'b1;
    req_insert = ins;
    req_key    = key;
    predict(ins, key);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code, cam_full, count} !== 17'd0) begin
      errors++;
      $display("FAIL reset_in: v=%b h=%b i=%b code=%0d full=%b count=%0d want all 0",
               rsp_valid, rsp_hit, rsp_inserted, rsp_code, cam_full, count);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code, cam_full, count, req_ready} !== 18'd1) begin
      errors++;
      $display("FAIL reset_out: v=%b code=%0d full=%b count=%0d ready=%b want 0/0/0/0/1",
               rsp_valid, rsp_code, cam_full, count, req_ready);
    end
  endtask

  task automatic test_fill();
    logic [18:0] keys[4];
    exp_t e;
    keys = '{19'h00141, 19'h00142, 19'h00143, 19'h00144};
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, keys[k]);
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code} !== {1'b1, e.hit, e.ins, e.code}) begin
        errors++;
        $display("FAIL fill[%0d]: got v=%b h=%b i=%b code=%0d want v=1 h=%b i=%b code=%0d",
                 k, rsp_valid, rsp_hit, rsp_inserted, rsp_code, e.hit, e.ins, e.code);
      end
    end
    checks++;
    if (cam_full !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d want 1 4", cam_full, count);
    end
    idle();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_code !== 11'd259 || rsp_inserted !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: v=%b i=%b code=%0d want 0 1 259", rsp_valid, rsp_inserted, rsp_code);
    end
  endtask

  task automatic test_search_and_full();
    logic [18:0] keys[4];
    logic        ins[4];
    exp_t e;
    keys = '{19'h00143, 19'h7FFFF, 19'h00150, 19'h00141};
    ins  = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      issue(ins[k], keys[k]);
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code} !== {1'b1, e.hit, e.ins, e.code}) begin
        errors++;
        $display("FAIL search[%0d]: got v=%b h=%b i=%b code=%0d want v=1 h=%b i=%b code=%0d",
                 k, rsp_valid, rsp_hit, rsp_inserted, rsp_code, e.hit, e.ins, e.code);
      end
      checks++;
      if (count !== 3'd4 || cam_full !== 1'b1) begin
        errors++;
        $display("FAIL full_hold[%0d]: count=%0d full=%b want 4 1", k, count, cam_full);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    model_keys.delete();
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, 19'h12345);
      e = sb.pop_front();
      checks++;
      if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code} !== {1'b1, e.hit, e.ins, e.code}) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b h=%b i=%b code=%0d want v=1 h=%b i=%b code=%0d",
                 k, rsp_valid, rsp_hit, rsp_inserted, rsp_code, e.hit, e.ins, e.code);
      end
    end
    checks++;
    if (count !== 3'd1 || cam_full !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: count=%0d full=%b want 1 0", count, cam_full);
    end
    idle();
  endtask

  task automatic test_flush();
    exp_t e;
    issue(1'b1, 19'h00141);
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code} !== {1'b1, e.hit, e.ins, e.code}) begin
      errors++;
      $display("FAIL pre_flush: got h=%b i=%b code=%0d want h=%b i=%b code=%0d",
               rsp_hit, rsp_inserted, rsp_code, e.hit, e.ins, e.code);
    end
    clear      = 1'b1;
    req_valid  = 1'b1;
    req_insert = 1'b1;
    req_key    = 19'h00150;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: req_ready=%b want 0", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    clear     = 1'b0;
    req_valid = 1'b0;
    model_keys.delete();
    checks++;
    if (rsp_valid !== 1'b0 || count !== 3'd0 || cam_full !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: v=%b count=%0d full=%b want 0 0 0", rsp_valid, count, cam_full);
    end
    issue(1'b0, 19'h00141);
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code} !== {1'b1, e.hit, e.ins, e.code}) begin
      errors++;
      $display("FAIL post_flush: got v=%b h=%b i=%b code=%0d want v=1 h=%b i=%b code=%0d",
               rsp_valid, rsp_hit, rsp_inserted, rsp_code, e.hit, e.ins, e.code);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    issue(1'b1, 19'h00AAA);
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code} !== {1'b1, e.hit, e.ins, e.code}) begin
      errors++;
      $display("FAIL pre_rst: got h=%b i=%b code=%0d want h=%b i=%b code=%0d",
               rsp_hit, rsp_inserted, rsp_code, e.hit, e.ins, e.code);
    end
    req_valid  = 1'b1;
    req_insert = 1'b1;
    req_key    = 19'h00BBB;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || count !== 3'd0 || cam_full !== 1'b0 ||
        rsp_code !== 11'd0 || rsp_inserted !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: v=%b i=%b code=%0d count=%0d full=%b want all 0",
               rsp_valid, rsp_inserted, rsp_code, count, cam_full);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    model_keys.delete();
    @(negedge clk);
    issue(1'b0, 19'h00AAA);
    e = sb.pop_front();
    checks++;
    if ({rsp_valid, rsp_hit, rsp_inserted, rsp_code} !== {1'b1, e.hit, e.ins, e.code}) begin
      errors++;
      $display("FAIL post_rst: got v=%b h=%b i=%b code=%0d want v=1 h=%b i=%b code=%0d",
               rsp_valid, rsp_hit, rsp_inserted, rsp_code, e.hit, e.ins, e.code);
    end
    idle();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b0;
    clear      = 1'b0;
    req_valid  = 1'b0;
    req_insert = 1'b0;
    req_key    = '0;
    test_reset();
    test_fill();
    test_search_and_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lzw_cam_dict.md
# lzw_cam_dict

Parametrised content-addressable dictionary for the 11-bit LZW compressor. It generalises the single CAM cell to DEPTH entries with a request/response handshake, search-or-insert operation, code generation and flush. It sits between the compressor FSM and the code emitter. Each request looks up a {prefix code, next char} key and returns the matching dictionary code. On a miss it can allocate the next free code.

## Interface
Parameters:
- CHAR_W, 8, symbol width
- CODE_W, 11, dictionary code width
- KEY_W, CODE_W+CHAR_W (19), stored key width
- CODE_BASE, 256, first code assigned to a dictionary entry (codes below are literals)
- DEPTH, 2**CODE_W-CODE_BASE (1792), number of entries; must satisfy CODE_BASE+DEPTH <= 2**CODE_W

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of every entry
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted; combinational, equal to ~clear
- req_insert  in  1  1 = search and insert on miss; 0 = search only
- req_key  in  KEY_W  key to look up
- rsp_valid  out  1  one-cycle pulse carrying the response
- rsp_hit  out  1  key was present
- rsp_inserted  out  1  key was newly written
- rsp_code  out  CODE_W  matching or newly allocated code
- cam_full  out  1  all DEPTH entries valid
- count  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: DEPTH slots, each with a key register and a valid bit. Slots fill in index order 0..DEPTH-1 from a write pointer equal to count. Codes are never freed individually.
- Accept: a request is accepted when req_valid && req_ready at a rising edge. The compare uses slot contents as they stand before that edge.
- Hit: rsp_hit=1, rsp_inserted=0, rsp_code=CODE_BASE+matching index. Storage is unchanged. Duplicates cannot be created. If a multi-hit ever occurs, the lowest index wins.
- Miss, req_insert=1, not full: slot[count] takes the key and becomes valid, and count increments. Response is rsp_hit=0, rsp_inserted=1, rsp_code=CODE_BASE+old count.
- Miss, req_insert=0, or miss while full: rsp_hit=0, rsp_inserted=0, rsp_code=0. Storage is unchanged.
- Flush: clear=1 at an edge zeroes every valid bit and count, and sets cam_full=0. Stored keys need not be zeroed. clear has priority: req_ready=0, so a concurrent request is not accepted and produces no response.
- Width rule: code arithmetic is CODE_W bits and cannot overflow given the DEPTH constraint.

## Timing
- Reset values: rsp_valid=0, rsp_hit=0, rsp_inserted=0, rsp_code=0, cam_full=0, count=0, all valid bits 0. req_ready follows ~clear.
- Latency: a request accepted at edge N gives rsp_valid=1 with all response fields during the cycle after edge N. Response fields are registered.
- Throughput is one request per cycle, with no stall and no output backpressure. When no request is accepted, rsp_valid=0 and the other rsp_* fields hold their last values.
- Back-to-back requests: an insert at edge N is visible to the request accepted at edge N+1. The same key sent twice in a row returns inserted, then hit, with the same code.
- count and cam_full update at the same edge as the write. cam_full is registered and equals (count==DEPTH).
- Reset asserted mid-operation clears everything immediately. No response is produced for a request in flight.

## Structure
- Shared package lzw_pkg holds:
  - constants CHAR_W, CODE_W, CODE_BASE and the derived DEPTH;
  - typedefs code_t (logic [CODE_W-1:0]), char_t, and key_t as a packed struct {code_t prefix; char_t ch}.
- Sub-module cam_slot: one key register, valid bit, equality comparator and write enable; output match = valid && key==search. lzw_cam_dict instantiates it DEPTH times with a generate loop.
- The top holds the priority encoder (lowest index), the write pointer/count, and the response registers.

## Test plan
All scenarios use DEPTH=4 and CODE_BASE=256.
- Reset: apply rst=0 then release → all outputs are 0, req_ready=1, count=0.
- Fill: insert keys 0x00141, 0x00142, 0x00143, 0x00144 on consecutive cycles → each response has rsp_inserted=1 and codes 256, 257, 258, 259; after the last, cam_full=1 and count=4.
- Search: search-only for 0x00143 → rsp_hit=1, rsp_code=258. Search-only for 0x7FFFF → rsp_hit=0, rsp_code=0, count unchanged.
- Full boundary: insert 0x00150 while full → rsp_hit=0, rsp_inserted=0, count stays 4. Insert the existing key 0x00141 → rsp_hit=1, code 256.
- Back-to-back duplicate: from empty, insert 0x12345 twice in consecutive cycles → first response inserted with code 256, second response hit with code 256, count=1.
- Flush and reset mid-stream: assert clear together with req_valid → no response follows, count=0, cam_full=0, and a later search for 0x00141 misses. Then assert rst during an accepted request → rsp_valid stays 0 and all state is cleared.
